// File: rtl/presc_counter.sv
// presc_counter: prescaled modulo counter with load and terminal-count pulse.
// Define PRESC_COUNTER_UPDN_EN to honour dir (up/down); otherwise counts up only.
module presc_counter #(
  parameter int WIDTH = 4,
  parameter int DIV_BITS = 23,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             re,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] c,
  output logic             tc
);
  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] c_q, c_d, nxt_c, lim_val;
  logic tc_q, tc_d, step, wrap;
`ifdef PRESC_COUNTER_UPDN_EN
  always_comb begin
    nxt_c = dir ? ((c_q >= MAX_VAL) ? '0 : c_q + 1'b1) : ((c_q == '0) ? MAX_VAL : c_q - 1'b1);
    wrap  = dir ? (c_q >= MAX_VAL) : (c_q == '0);
  end
`else
  logic unused_dir;
  assign unused_dir = dir;
  always_comb begin
    nxt_c = (c_q >= MAX_VAL) ? '0 : c_q + 1'b1;
    wrap  = c_q >= MAX_VAL;
  end
`endif
  always_comb begin
    step    = en & ~load & (presc_q == '1);
    lim_val = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    presc_d = load ? '0 : en ? presc_q + 1'b1 : presc_q;
    c_d     = load ? lim_val : step ? nxt_c : c_q;
    tc_d    = step & wrap;
  end
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      presc_q <= '0;
      c_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      c_q     <= c_d;
      tc_q    <= tc_d;
    end
  end
  assign c  = c_q;
  assign tc = tc_q;
endmodule

// File: tb/tb_presc_counter.sv
// tb_presc_counter: directed table-driven bench for presc_counter (small and default configs).
module tb_presc_counter;
  logic clk = 1'b0, re, en, load, dir;
  logic [3:0] load_val, c, c2;
  logic tc, tc2;
  int total = 0, bad = 0, n2 = 0;

  typedef struct {
    logic en, load;
    logic [3:0] lv;
    logic [3:0] c;
    logic tc;
    int p;
  } vec_t;
  vec_t tbl[24];

  always #5 clk = ~clk;

  presc_counter #(.WIDTH(4), .DIV_BITS(2), .MAX_VAL(4'd9)) dut (
    .clk(clk), .re(re), .en(en), .load(load), .load_val(load_val), .dir(dir), .c(c), .tc(tc));

  presc_counter d2 (
    .clk(clk), .re(re), .en(1'b1), .load(1'b0), .load_val(4'd0), .dir(1'b1), .c(c2), .tc(tc2));

  always @(posedge clk) n2 <= re ? n2 + 1 : 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string nm, input int ec, input int etc, input int ep);
    chk({nm, ".c"}, int'(c), ec);
    chk({nm, ".tc"}, int'(tc), etc);
    chk({nm, ".presc"}, int'(dut.presc_q), ep);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 1};
    tbl[1] = '{1, 0, 0, 0, 0, 2};
    for (int i = 2; i <= 8; i++) tbl[i] = '{0, 0, 0, 0, 0, 2};
    tbl[9]  = '{1, 0, 0, 0, 0, 3};
    tbl[10] = '{1, 0, 0, 1, 0, 0};
    tbl[11] = '{1, 1, 14, 9, 0, 0};
    tbl[12] = '{1, 0, 0, 9, 0, 1};
    tbl[13] = '{1, 0, 0, 9, 0, 2};
    tbl[14] = '{1, 0, 0, 9, 0, 3};
    tbl[15] = '{1, 1, 5, 5, 0, 0};
    tbl[16] = '{1, 1, 14, 9, 0, 0};
    tbl[17] = '{1, 0, 0, 9, 0, 1};
    tbl[18] = '{1, 0, 0, 9, 0, 2};
    tbl[19] = '{1, 0, 0, 9, 0, 3};
    tbl[20] = '{1, 0, 0, 0, 1, 0};
    tbl[21] = '{0, 0, 0, 0, 0, 0};
    tbl[22] = '{0, 1, 3, 3, 0, 0};
    tbl[23] = '{0, 1, 9, 9, 0, 0};

    re = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; dir = 1'b1;
    tick(); tick();
    chk3("reset", 0, 0, 0);
    re = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("run.c", int'(c), (k / 4) % 10);
      chk("run.tc", int'(tc), ((k % 4 == 0) && ((k / 4) % 10 == 0)) ? 1 : 0);
    end

    for (int i = 0; i < 24; i++) begin
      en = tbl[i].en; load = tbl[i].load; load_val = tbl[i].lv;
      tick();
      chk3($sformatf("vec%0d", i), int'(tbl[i].c), int'(tbl[i].tc), tbl[i].p);
    end

    // down count from 1, then a mid-period direction flip
    en = 1'b1; load = 1'b1; load_val = 4'd1; dir = 1'b0;
    tick();
    load = 1'b0;
    chk3("dn.load", 1, 0, 0);
    repeat (4) tick();
`ifdef PRESC_COUNTER_UPDN_EN
    chk3("dn.s1", 0, 0, 0);
`else
    chk3("dn.s1", 2, 0, 0);
`endif
    repeat (4) tick();
`ifdef PRESC_COUNTER_UPDN_EN
    chk3("dn.s2", 9, 1, 0);
`else
    chk3("dn.s2", 3, 0, 0);
`endif
    tick();
    chk("dn.tcdrop", int'(tc), 0);
    dir = 1'b1;
    tick(); tick();
    chk("flip.nostep", int'(tc), 0);
    tick();
`ifdef PRESC_COUNTER_UPDN_EN
    chk3("flip.step", 0, 1, 0);
`else
    chk3("flip.step", 4, 0, 0);
`endif

    // asynchronous reset mid-period at c=7, presc=3
    load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0;
    repeat (3) tick();
    chk3("pre_rst", 7, 0, 3);
    #2 re = 1'b0;
    #1 chk3("async_rst", 0, 0, 0);
    tick();
    re = 1'b1;
    repeat (3) tick();
    chk3("rst.resume3", 0, 0, 3);
    tick();
    chk3("rst.resume4", 1, 0, 0);

    repeat (200) tick();
    chk("def.c", int'(c2), 0);
    chk("def.tc", int'(tc2), 0);
    chk("def.presc", int'(d2.presc_q), n2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/presc_counter.md
PRESC_COUNTER -- requirements
Module: presc_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 SHALL provide parameter DIV_BITS, default 23, prescaler width; one count step every 2^DIV_BITS enabled clocks (1..32).
REQ-003 SHALL provide parameter MAX_VAL, default 2^WIDTH-1, terminal (modulus-1) value; legal range 1..2^WIDTH-1.
REQ-004 SHALL have port clk  input  1  single rising-edge clock; the only clock in the block.
REQ-005 SHALL have port re  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  count enable; gates prescaler and counter.
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  WIDTH  value loaded on load.
REQ-009 SHALL have port dir  input  1  count direction, 1=up, 0=down (honoured only per REQ-024).
REQ-010 SHALL have port c  output  WIDTH  registered count value.
REQ-011 SHALL have port tc  output  1  registered terminal-count pulse.

Function
REQ-012 SHALL hold internal prescaler presc[DIV_BITS-1:0]; no derived or divided clocks; all state on clk.
REQ-013 SHALL define a step edge as a rising clk edge with re=1, load=0, en=1 and presc=2^DIV_BITS-1.
REQ-014 SHALL increment presc by 1 on each edge with re=1, load=0, en=1; at a step edge presc wraps to 0.
REQ-015 SHALL update c only at step edges; first step occurs exactly 2^DIV_BITS enabled clocks after reset or load.
REQ-016 SHALL, counting up at a step edge, set c=c+1, or c=0 when c>=MAX_VAL.
REQ-017 SHALL, counting down at a step edge, set c=c-1, or c=MAX_VAL when c=0.
REQ-018 SHALL assert tc for exactly one clk cycle following a step edge that wrapped c (MAX_VAL->0 up, 0->MAX_VAL down); tc=0 otherwise.
REQ-019 SHALL hold presc, c unchanged and drive tc=0 on any edge with en=0.
REQ-020 SHALL, on any edge with load=1 (priority over en and step), set c=load_val, or MAX_VAL if load_val>MAX_VAL; presc=0; tc=0.
REQ-021 SHALL treat a dir change between steps as taking effect at the next step edge; no extra step or tc generated.

Reset
REQ-022 SHALL, while re=0, force c=0, presc=0, tc=0 immediately without waiting for clk.
REQ-023 SHALL resume counting on the first clk edge after re deasserts, counting from presc=0; reset mid-prescale discards the partial period.

Configuration
REQ-024 SHALL honour macro PRESC_COUNTER_UPDN_EN: defined -> dir selects up/down per REQ-016/017; undefined -> dir ignored, block counts up only, down logic not synthesised.

Verification (WIDTH=4, DIV_BITS=2, MAX_VAL=9 unless stated)
REQ-025 SHALL cover: re=0 then release, en=1 for 40 clks -> c steps 0,1,..,9,0 every 4 clks; tc one-cycle pulse after the 9->0 step only.
REQ-026 SHALL cover: en=1, drop en for 7 clks mid-period (presc=2) -> c and presc frozen; next step occurs 2 enabled clks after en returns.
REQ-027 SHALL cover: load=1 with load_val=14 -> c=9, presc=0, tc=0; load_val=5 simultaneous with a step edge -> c=5, no step.
REQ-028 SHALL cover (macro defined): dir=0 from c=1 -> c=1,0,9 at successive steps; tc pulse after 0->9; macro undefined, dir=0 -> c still increments.
REQ-029 SHALL cover: re asserted asynchronously between clk edges at c=7, presc=3 -> c=0, presc=0, tc=0 before next edge; step resumes 4 clks after release.
REQ-030 SHALL cover defaults WIDTH=4, DIV_BITS=23, MAX_VAL=15: c increments once per 8388608 enabled clks, wraps 15->0 with tc pulse.
